req_encoder: RTL and testbench
==============================

Name: req_encoder

Overview:
- Request-side counterpart of the 3-to-8 decoder in the traffic controller datapath: collects up to 8 independent one-bit request lines and encodes the winner into a 3-bit code for the controller.
- Latches requests into a pending register and arbitrates round-robin among them.
- Presents each grant as code/valid, which holds until the consumer acknowledges or a timeout expires.

Parameters:
TIMEOUT, 15, cycles a grant may remain unacknowledged before it is abandoned; 0 disables the timeout.
CW, 4, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req    input  8  request lines, bit k = source k, sampled every rising edge
ack    input  1  consumer accepts the current code; ignored while valid=0
err_clr  input  1  synchronous clear of the sticky err flag
valid  output  1  code is a live grant
code   output  3  binary index of the granted source
pend   output  8  pending-request register, for visibility
err    output  1  sticky flag: at least one grant timed out

Behaviour:
- Reset (reset=0, asynchronous, no clock edge needed): valid=0, code=0, pend=0, err=0, round-robin pointer ptr=0, timeout counter cnt=0, state=IDLE. Reset mid-grant drops the grant immediately. Operation resumes on the first rising edge after reset=1.
- Pending update, every edge: pend[k] <= pend[k] | req[k].
  - The granted bit is cleared on grant retirement (ack or timeout).
  - If req[code]=1 on the retiring edge, set wins and pend[code] stays 1.
- States: IDLE and PRESENT.
- IDLE:
  - If pend != 0, search from ptr upward, wrapping 7->0, for the first set bit j.
  - On that edge: code<=j, valid<=1, cnt<=0, go to PRESENT.
  - If pend == 0, stay in IDLE with valid=0; code holds its last value.
- PRESENT:
  - code and valid are held stable.
  - ack=1 at an edge: valid<=0, retire pend[code], ptr<=(code+1) mod 8, go to IDLE.
  - Otherwise, with TIMEOUT>0 and cnt==TIMEOUT-1: same retirement as ack, plus err<=1.
  - Otherwise cnt<=cnt+1.
  - ack and timeout on the same edge: ack wins, err is not set.
- Latency:
  - req[k] sampled at edge t -> pend[k]=1 after t -> valid=1, code=k after edge t+1 (if IDLE and k is first from ptr).
  - After retirement at edge u, valid is 0 for exactly one cycle; the next grant is visible earliest after edge u+1.
- With no ack, valid stays high for exactly TIMEOUT cycles.
- err: set as above; cleared by err_clr=1 at an edge. Set and clear on the same edge: set wins.
- ack while valid=0 has no effect.
- All-zero req with pend=0: the block idles indefinitely with outputs stable.

Test Plan:
1. Single request:
   - Stimulus: req=8'h04 for one cycle at edge t; ack=1 at edge t+3.
   - Required: pend=8'h04 after t; valid=1, code=2 after t+1, held through t+3; valid=0, pend=0 after t+3.
2. All sources at once:
   - Stimulus: req=8'hFF for one cycle from reset; ack=1 constantly.
   - Required: codes granted 0,1,...,7 in order, valid pulses 1 cycle high / 1 cycle low; pend=0 after the 8th ack.
3. Round-robin fairness:
   - Stimulus: req=8'h42 held continuously; ack=1 constantly.
   - Required: code sequence 1,6,1,6,...; pend[1] and pend[6] never clear (set wins).
4. Timeout:
   - Stimulus: TIMEOUT=4, req=8'h20 one cycle, ack=0.
   - Required: valid high exactly 4 cycles with code=5, then valid=0, err=1, pend=0.
   - Follow-up: err_clr=1 for one cycle -> err=0.
5. Ack on the timeout edge:
   - Stimulus: TIMEOUT=4, ack=1 on the 4th cycle of the grant.
   - Required: valid=0, err stays 0, ptr advances past the granted code.
6. Reset mid-grant:
   - Stimulus: drive reset=0 between clock edges while valid=1, code=3, pend=8'h88.
   - Required: valid, code, pend, err go to 0 immediately without a clock edge; after release, a new req=8'h01 gives code=0 with the normal latency.

Source files
------------

// File: rtl/req_encoder.sv
// req_encoder: 8-source request encoder with round-robin arbitration.
// Each request line sets a pending bit. The arbiter picks the next pending
// source at or after the round-robin pointer. The winner is shown as a
// code/valid grant until it is acknowledged or until it times out.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset
//   req     - request lines, bit k = source k
//   ack     - consumer accepts the current code (ignored while valid=0)
//   err_clr - synchronous clear of the sticky err flag
//   valid   - code is a live grant
//   code    - binary index of the granted source
//   pend    - pending-request register
//   err     - sticky flag: at least one grant timed out

// One pending bit per source. A new request on the retiring edge beats the
// clear, so a source that keeps requesting is never lost.
module req_encoder_lane (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic clr,
  output logic pend
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) pend <= 1'b0;
    else        pend <= (pend & ~clr) | req;
endmodule

module req_encoder #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       ack,
  input  logic       err_clr,
  output logic       valid,
  output logic [2:0] code,
  output logic [7:0] pend,
  output logic       err
);
  localparam int NUM_LANES = 8;
  localparam bit TO_EN = (TIMEOUT > 0);
  // Counter value on the final allowed cycle of a grant.
  localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t         state, state_d;
  logic [2:0]     ptr, ptr_d, code_d, sel, probe;
  logic [CW-1:0]  cnt, cnt_d;
  logic           hit, ack_fire, to_fire, retire, err_d;
  logic [NUM_LANES-1:0] clr_mask;

  // The granted lane is cleared only on the edge where its grant retires.
  req_encoder_lane u_lane [NUM_LANES-1:0] (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .clr   (clr_mask),
    .pend  (pend)
  );

  // Round-robin search. Offsets are scanned from high to low, so the
  // smallest offset from ptr that has a pending bit is the last one
  // assigned and therefore wins.
  always_comb begin
    hit   = |pend;
    sel   = ptr;
    probe = ptr;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      probe = ptr + 3'(i);
      if (pend[probe]) sel = probe;
    end
  end

  assign ack_fire = (state == PRESENT) && ack;
  // If ack and timeout land on the same edge, ack takes priority.
  assign to_fire  = TO_EN && (state == PRESENT) && !ack && (cnt == TO_LAST);
  assign retire   = ack_fire || to_fire;
  assign clr_mask = retire ? (NUM_LANES'(1) << code) : '0;
  // A timeout that sets err on the same edge as err_clr keeps err set.
  assign err_d    = to_fire || (err && !err_clr);

  // State register, together with the registered grant context.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      code  <= '0;
      ptr   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      code  <= code_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      err   <= err_d;
    end

  // Next-state logic.
  always_comb begin
    state_d = state;
    code_d  = code;
    ptr_d   = ptr;
    cnt_d   = cnt;
    case (state)
      IDLE:
        if (hit) begin
          state_d = PRESENT;
          code_d  = sel;
          cnt_d   = '0;
        end
      PRESENT:
        if (retire) begin
          state_d = IDLE;
          ptr_d   = code + 3'd1;
        end else begin
          cnt_d   = cnt + CW'(1);
        end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    valid = (state == PRESENT);
  end
endmodule

// File: tb/tb_req_encoder.sv
// Self-checking bench for req_encoder. The DUT is built with TIMEOUT=4.
// A cycle-level reference model is compared against the DUT outputs on every
// falling edge. Directed checks with hand-computed values also pin the model.
module tb_req_encoder;
  localparam int TO = 4;

  logic       clock, reset, ack, err_clr, valid, err;
  logic [7:0] req, pend;
  logic [2:0] code;

  int  npass = 0, ntot = 0;
  bit  chk_en = 0;

  req_encoder #(.TIMEOUT(TO), .CW(4)) dut (
    .clock(clock), .reset(reset), .req(req), .ack(ack), .err_clr(err_clr),
    .valid(valid), .code(code), .pend(pend), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model. A grant has an age equal to the number of cycles it has
  // been visible. When the age reaches TO with no ack, the grant is abandoned.
  typedef struct packed {
    logic [7:0] pend;
    logic       busy;
    logic [2:0] code;
    logic [2:0] ptr;
    logic [7:0] age;
    logic       err;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t mnext(mstate_t s, logic [7:0] r, logic a, logic c);
    mstate_t n;
    bit retire, tmo;
    int j;
    n = s;
    retire = 0;
    tmo = 0;
    if (s.busy) begin
      n.age = s.age + 8'd1;
      if (a) retire = 1;
      else if (TO != 0 && int'(n.age) == TO) begin retire = 1; tmo = 1; end
    end
    n.err  = tmo || (s.err && !c);
    n.pend = s.pend | r;
    if (retire) begin
      n.pend[s.code] = r[s.code];
      n.busy = 0;
      n.ptr  = 3'((int'(s.code) + 1) % 8);
    end else if (!s.busy && s.pend != 0) begin
      for (int i = 7; i >= 0; i--) begin
        j = (int'(s.ptr) + i) % 8;
        if (s.pend[j]) begin n.code = 3'(j); n.busy = 1; n.age = 0; end
      end
    end
    return n;
  endfunction

  always @(posedge clock or negedge reset)
    if (!reset) m <= '0;
    else        m <= mnext(m, req, ack, err_clr);

  always @(negedge clock)
    if (chk_en && reset) begin
      chk("model valid", {31'd0, valid}, {31'd0, m.busy});
      chk("model code",  {29'd0, code},  {29'd0, m.code});
      chk("model pend",  {24'd0, pend},  {24'd0, m.pend});
      chk("model err",   {31'd0, err},   {31'd0, m.err});
    end

  task automatic cyc(input logic [7:0] r, input logic a, input logic c);
    req = r; ack = a; err_clr = c;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, {31'd0, valid}, 32'd0);
    chk({nm, " code"},  {29'd0, code},  32'd0);
    chk({nm, " pend"},  {24'd0, pend},  32'd0);
    chk({nm, " err"},   {31'd0, err},   32'd0);
  endtask

  task automatic do_reset();
    req = 0; ack = 0; err_clr = 0;
    #2 reset = 1'b0;
    #1;
    @(negedge clock);
    #1 reset = 1'b1;
  endtask

  logic [2:0] seen[$];
  int hc;
  bit was_hi;

  initial begin
    reset = 1'b0; req = 0; ack = 0; err_clr = 0;
    #1 chk_zero("reset state");
    @(negedge clock);
    #1 reset = 1'b1;
    chk_en = 1;

    // 1: single request. Pending after t, granted after t+1, retired at t+3.
    cyc(8'h04, 0, 0);
    chk("t1 pend", {24'd0, pend}, 32'h04);
    chk("t1 valid0", {31'd0, valid}, 32'd0);
    cyc(8'h00, 0, 0);
    chk("t1 valid", {31'd0, valid}, 32'd1);
    chk("t1 code", {29'd0, code}, 32'd2);
    cyc(8'h00, 0, 0);
    chk("t1 hold", {31'd0, valid}, 32'd1);
    cyc(8'h00, 1, 0);
    chk("t1 retire valid", {31'd0, valid}, 32'd0);
    chk("t1 retire pend", {24'd0, pend}, 32'd0);
    cyc(8'h00, 1, 0);
    chk("t1 idle ack ignored", {31'd0, valid}, 32'd0);

    // 2: all sources at once. Grants must come out in order 0..7.
    do_reset();
    cyc(8'hFF, 1, 0);
    seen.delete();
    for (int i = 0; i < 16; i++) begin
      cyc(8'h00, 1, 0);
      if (valid) seen.push_back(code);
    end
    chk("t2 grants", seen.size(), 32'd8);
    for (int i = 0; i < seen.size() && i < 8; i++)
      chk("t2 order", {29'd0, seen[i]}, i);
    chk("t2 pend", {24'd0, pend}, 32'd0);

    // 3: fairness between two sources that keep requesting.
    do_reset();
    seen.delete();
    for (int i = 0; i < 12; i++) begin
      cyc(8'h42, 1, 0);
      if (valid) seen.push_back(code);
    end
    chk("t3 grants", seen.size(), 32'd6);
    for (int i = 0; i < seen.size() && i < 6; i++)
      chk("t3 rr", {29'd0, seen[i]}, (i % 2) ? 32'd6 : 32'd1);
    chk("t3 pend", {24'd0, pend}, 32'h42);

    // 4: timeout. valid must stay high for exactly TO cycles, then err is set.
    do_reset();
    cyc(8'h20, 0, 0);
    hc = 0; was_hi = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(8'h00, 0, 0);
      if (valid && code == 3'd5) begin hc++; was_hi = 1; end
      else if (was_hi) break;
    end
    chk("t4 high cycles", hc, TO);
    chk("t4 valid", {31'd0, valid}, 32'd0);
    chk("t4 err", {31'd0, err}, 32'd1);
    chk("t4 pend", {24'd0, pend}, 32'd0);
    cyc(8'h00, 0, 1);
    chk("t4 err_clr", {31'd0, err}, 32'd0);

    // 5: ack on the timeout edge beats the timeout. The pointer then moves
    // past code 1, so the next grant must be source 0.
    do_reset();
    cyc(8'h02, 0, 0);
    cyc(8'h00, 0, 0);
    chk("t5 grant", {29'd0, code}, 32'd1);
    cyc(8'h00, 0, 0);
    cyc(8'h00, 0, 0);
    cyc(8'h00, 0, 0);
    chk("t5 still valid", {31'd0, valid}, 32'd1);
    cyc(8'h03, 1, 0);
    chk("t5 valid", {31'd0, valid}, 32'd0);
    chk("t5 err", {31'd0, err}, 32'd0);
    chk("t5 pend", {24'd0, pend}, 32'h03);
    cyc(8'h00, 0, 0);
    chk("t5 ptr", {29'd0, code}, 32'd0);
    cyc(8'h00, 1, 0);

    // 6: an asynchronous reset in the middle of a grant.
    do_reset();
    cyc(8'h88, 0, 0);
    cyc(8'h00, 0, 0);
    chk("t6 pre valid", {31'd0, valid}, 32'd1);
    chk("t6 pre code", {29'd0, code}, 32'd3);
    chk("t6 pre pend", {24'd0, pend}, 32'h88);
    #2 reset = 1'b0;
    #1 chk_zero("t6 async");
    @(negedge clock);
    #1 reset = 1'b1;
    cyc(8'h01, 0, 0);
    chk("t6 post valid0", {31'd0, valid}, 32'd0);
    cyc(8'h00, 0, 0);
    chk("t6 post valid", {31'd0, valid}, 32'd1);
    chk("t6 post code", {29'd0, code}, 32'd0);
    cyc(8'h00, 1, 0);
    cyc(8'h00, 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
